// File: rtl/io_tube_ctrl.sv
// io_tube_ctrl: memory-mapped eight-digit seven-segment tube controller.
// Holds a 16-bit display value and a 3-bit control register written over the
// CPU IO path, converts the value to BCD with a sequential double-dabble
// engine, and time-multiplexes the digits onto a common-anode tube.
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   wr_en    IO write strobe, one cycle per write
//   wr_sel   0 = data register, 1 = control register
//   wr_data  write data
//   busy     decimal conversion in progress
//   seg_en   digit enables, active low, bit i = digit i (digit 0 rightmost)
//   seg_out  segments, active low, {dp,g,f,e,d,c,b,a}
module io_tube_ctrl #(
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out
);

  localparam int unsigned DW  = 16;
  localparam int unsigned BW  = 20;
  localparam int unsigned SW  = BW + DW;
  localparam int unsigned PW  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   data_q;
  logic [2:0]      ctrl_q;
  logic [BW-1:0]   bcd_disp_q, bcd_disp_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q;
  logic [PW-1:0]   presc_q;
  logic [2:0]      idx_q;
  logic [7:0]      seg_en_q, seg_en_d;
  logic [7:0]      seg_out_q, seg_out_d;

  logic            start_c;
  logic [DW-1:0]   start_val_c;
  logic [BW-1:0]   bcd_adj_c;
  logic [SW-1:0]   shift_pre_c;

  // Segment pattern for a hex nibble, dp off.
  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

  // Register writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      ctrl_q <= 3'b100;
    end else if (wr_en) begin
      if (wr_sel) ctrl_q <= wr_data[2:0];
      else        data_q <= wr_data;
    end
  end

  // A data write converts when dec mode is already on; a control write
  // converts the held value when it turns dec mode on (or keeps it on).
  always_comb begin
    start_c     = wr_en & (wr_sel ? wr_data[0] : ctrl_q[0]);
    start_val_c = wr_sel ? data_q : wr_data;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; a start always wins and restarts the conversion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_SHIFT: if (cnt_q == CW'(15)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (start_c) state_d = S_SHIFT;
  end

  // Double-dabble add-3 correction on every BCD nibble.
  always_comb begin
    bcd_adj_c = '0;
    for (int i = 0; i < 5; i++) begin
      if (shift_q[DW + 4*i +: 4] >= 4'd5)
        bcd_adj_c[4*i +: 4] = shift_q[DW + 4*i +: 4] + 4'd3;
      else
        bcd_adj_c[4*i +: 4] = shift_q[DW + 4*i +: 4];
    end
    shift_pre_c = {bcd_adj_c, shift_q[DW-1:0]};
  end

  // FSM outputs: converter datapath and result capture.
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    bcd_disp_d = bcd_disp_q;
    if (start_c) begin
      shift_d = {BW'(0), start_val_c};
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_SHIFT: begin
          shift_d = {shift_pre_c[SW-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
        end
        S_DONE:  bcd_disp_d = shift_q[SW-1:DW];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      bcd_disp_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      bcd_disp_q <= bcd_disp_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  // Scan prescaler and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= idx_q + 3'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Digit selection, leading-zero blanking and segment encode.
  logic [3:0] dig_c [8];
  logic [7:0] avail_c;
  logic [2:0] msd_c;
  logic       blank_c;

  always_comb begin
    avail_c = ctrl_q[0] ? 8'h1F : 8'h0F;
    for (int i = 0; i < 8; i++) begin
      dig_c[i] = 4'h0;
      if (ctrl_q[0] && i < 5)       dig_c[i] = bcd_disp_q[4*i +: 4];
      else if (!ctrl_q[0] && i < 4) dig_c[i] = data_q[4*i +: 4];
    end
    msd_c = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (avail_c[i] && dig_c[i] != 4'h0) msd_c = 3'(i);
    end
    // Digit 0 is never above msd, so it is never blanked by zero suppression.
    blank_c = !avail_c[idx_q] || (ctrl_q[1] && (idx_q > msd_c));
    seg_en_d  = 8'hFF;
    seg_out_d = 8'hFF;
    if (ctrl_q[2] && !blank_c) begin
      seg_en_d[idx_q] = 1'b0;
      seg_out_d       = seg_code(dig_c[idx_q]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_en_q  <= 8'hFF;
      seg_out_q <= 8'hFF;
    end else begin
      seg_en_q  <= seg_en_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign busy    = busy_q;
  assign seg_en  = seg_en_q;
  assign seg_out = seg_out_q;

endmodule
